// File: rtl/dsp_seq_pkg.sv
// ============================================================================
// Module      : dsp_seq_pkg
// Description : Shared types and helpers for the DSP job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_seq_pkg;

    localparam int PARAM_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        OUT     = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Bits needed to hold any value in 0..max_val (never less than one).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_seq_wdog.sv
// ============================================================================
// Module      : dsp_seq_wdog
// Description : LOAD stall watchdog; flags timeout_cycles consecutive stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_seq_wdog
    import dsp_seq_pkg::*;
#(
    parameter int timeout_cycles = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic in_load,
    input  logic stall,
    output logic timeout
);

    localparam int c_cnt_w = cnt_w(timeout_cycles);

    logic [c_cnt_w-1:0] r_cnt;

    // Any accept (in_load without stall) or leaving LOAD restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !in_load || !stall) begin
            r_cnt <= '0;
        end else if (r_cnt != c_cnt_w'(timeout_cycles)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout = in_load && stall && (r_cnt == c_cnt_w'(timeout_cycles - 1));

endmodule

`default_nettype wire

// File: rtl/dsp_seq.sv
// ============================================================================
// Module      : dsp_seq
// Description : Loads a job into a DSP, then reads results back one by one.
//               Optional LOAD watchdog enabled by macro DSP_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_seq
    import dsp_seq_pkg::*;
#(
    parameter int bus_width      = 24,
    parameter int load_words     = 2,
    parameter int read_words     = 2,
    parameter int timeout_cycles = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic [bus_width-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [bus_width-1:0] dsp_din,
    output logic                 dsp_we,
    output logic [PARAM_W-1:0]   dsp_param,
    input  logic [bus_width-1:0] dsp_dout,
    output logic [bus_width-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int c_lcnt_w = cnt_w(load_words);
    localparam int c_idx_w  = cnt_w(read_words - 1);

    if (load_words < 1 || read_words < 1 || read_words > 256 || timeout_cycles < 1) begin : g_cfg_check
        $error("dsp_seq: invalid parameter configuration");
    end

    state_t                r_state;
    state_t                w_next;
    logic [c_lcnt_w-1:0]   r_lcnt;
    logic [c_idx_w-1:0]    r_idx;
    logic [PARAM_W-1:0]    r_param;
    logic [bus_width-1:0]  r_m_data;
    logic                  r_m_valid;
    logic                  w_accept;
    logic                  w_last_load;
    logic                  w_last_read;
    logic                  w_timeout;

    assign w_accept    = s_valid && s_ready;
    assign w_last_load = w_accept && (r_lcnt == c_lcnt_w'(load_words - 1));
    assign w_last_read = (r_idx == c_idx_w'(read_words - 1));

    assign dsp_we    = w_accept;
    assign dsp_din   = s_data;
    assign dsp_param = r_param;
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;

`ifdef DSP_SEQ_TIMEOUT_EN
    dsp_seq_wdog #(
        .timeout_cycles (timeout_cycles)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .in_load (s_ready),
        .stall   (!s_valid),
        .timeout (w_timeout)
    );
    assign err = w_timeout;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b1;
        done    = 1'b0;
        s_ready = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (w_timeout)        w_next = IDLE;
                else if (w_last_load) w_next = ISSUE;
            end
            // WAIT covers the DSP's registered dout after the param update.
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = CAPTURE;
            CAPTURE: w_next = OUT;
            OUT: begin
                if (m_ready) w_next = w_last_read ? DONE : ISSUE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lcnt    <= '0;
            r_idx     <= '0;
            r_param   <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_lcnt <= '0;
                    r_idx  <= '0;
                end
                LOAD: begin
                    if (w_accept && r_lcnt != c_lcnt_w'(load_words)) r_lcnt <= r_lcnt + 1'b1;
                    if (w_last_load) r_idx <= '0;
                end
                ISSUE: r_param <= PARAM_W'(r_idx);
                CAPTURE: begin
                    r_m_data  <= dsp_dout;
                    r_m_valid <= 1'b1;
                end
                OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        if (!w_last_read) r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dsp_seq.sv
// ============================================================================
// Module      : tb_dsp_seq
// Description : Scoreboard bench for dsp_seq with a shift-register DSP model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_seq;

    localparam int BW = 24;
    localparam int LW = 2;
    localparam int RW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [BW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [BW-1:0] dsp_din;
    logic          dsp_we;
    logic [7:0]    dsp_param;
    logic [BW-1:0] dsp_dout;
    logic [BW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    dsp_seq #(
        .bus_width      (BW),
        .load_words     (LW),
        .read_words     (RW),
        .timeout_cycles (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .dsp_din   (dsp_din),
        .dsp_we    (dsp_we),
        .dsp_param (dsp_param),
        .dsp_dout  (dsp_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    // DSP model: newest written word sits at index 0, dout is registered.
    logic [BW-1:0] dw [LW];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LW; i++) dw[i] <= '0;
        end else if (dsp_we) begin
            for (int i = LW - 1; i > 0; i--) dw[i] <= dw[i-1];
            dw[0] <= dsp_din;
        end
        dsp_dout <= dw[int'(dsp_param) % LW];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] jw [LW];

    // Monitor: scoreboard pops, hold/latency/pulse checks, event counters.
    int            cyc = 0, last_we = 0, last_hs = 0, rd_idx = 0;
    int            we_cnt = 0, done_cnt = 0, err_cnt = 0;
    bit            first_pend = 0, prev_valid = 0, prev_ready = 0, prev_rst = 1, prev_done = 0;
    logic [BW-1:0] prev_data = '0;
    logic [BW-1:0] e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rd_idx = 0;
        end else begin
            if (dsp_we) begin
                we_cnt++;
                last_we    = cyc;
                first_pend = 1;
            end
            if (done) begin
                done_cnt++;
                chk("done_single_cycle", prev_done, 0);
            end
            if (err) err_cnt++;
            if (m_valid && !prev_valid) begin
                chk("dsp_param_idx", dsp_param, rd_idx);
                if (first_pend) chk("first_latency", cyc - last_we, 4);
                else            chk("read_period", cyc - last_hs, 4);
                first_pend = 0;
            end
            if (prev_valid && !prev_ready && !prev_rst) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", int'(exp_q.size() != 0), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e);
                end
                last_hs = cyc;
                rd_idx  = (rd_idx + 1) % RW;
            end
        end
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_rst   = rst;
        prev_data  = m_data;
        prev_done  = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int gap, input bit fixed);
        for (int i = 0; i < LW; i++) begin
            if (i > 0) repeat (gap) tick();
            jw[i]   = fixed ? BW'(i + 1) : BW'($urandom);
            s_data  = jw[i];
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            s_data  = '0;
        end
    endtask

    // Reading index p returns the p-th most recently loaded word.
    task automatic push_exp();
        for (int p = 0; p < RW; p++) exp_q.push_back(jw[LW - 1 - p]);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!m_valid && k < 20) begin
            tick();
            k++;
        end
        chk("m_valid_seen", m_valid, 1);
    endtask

    task automatic run_job(input int gap, input int bp, input bit spam, input bit fixed);
        int d0 = done_cnt;
        int w0 = we_cnt;
        int k  = 0;
        m_ready = (bp == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        do_load(gap, fixed);
        push_exp();
        if (spam) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (bp > 0) begin
            for (int r = 0; r < RW; r++) begin
                wait_valid();
                repeat (bp) tick();
                m_ready = 1'b1;
                tick();
                m_ready = 1'b0;
            end
        end
        while (!done && k < 60) begin
            tick();
            k++;
        end
        chk("done_seen", done, 1);
        if (spam) start = 1'b1;
        tick();
        start   = 1'b0;
        m_ready = 1'b0;
        chk("idle_after_done", busy, 0);
        repeat (2) tick();
        chk("done_count", done_cnt - d0, 1);
        chk("we_count", we_cnt - w0, LW);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("still_idle", busy, 0);
    endtask

    initial begin
        int d0, e0, seen;
        rst     = 1'b1;
        s_valid = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_dsp_we", dsp_we, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_dsp_param", dsp_param, 0);
        chk("rst_m_data", m_data, 0);
        s_valid = 1'b0;
        rst     = 1'b0;
        tick();

        run_job(0, 0, 0, 1);
        run_job(5, 0, 0, 1);
        run_job(0, 10, 0, 0);

        // Reset while a result is being presented.
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_load(0, 0);
        push_exp();
        wait_valid();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_m_valid", m_valid, 0);
        exp_q.delete();
        repeat (4) tick();
        chk("reset_no_done", done_cnt - d0, 0);
        run_job(0, 0, 0, 0);

        run_job(1, 0, 1, 0);

        for (int n = 0; n < 6; n++)
            run_job(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 0, 0);

        d0 = done_cnt;
        e0 = err_cnt;
        start = 1'b1;
        tick();
        start   = 1'b0;
        s_data  = BW'($urandom);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
`ifdef DSP_SEQ_TIMEOUT_EN
        seen = 0;
        for (int j = 1; j <= 12; j++) begin
            if (err) begin
                seen = j;
                break;
            end
            tick();
        end
        chk("err_after_stalls", seen, TO);
        tick();
        chk("idle_after_err", busy, 0);
        chk("err_pulses", err_cnt - e0, 1);
        chk("no_done_on_timeout", done_cnt - d0, 0);
`else
        seen = 0;
        repeat (20) tick();
        chk("no_err_without_wdog", err_cnt - e0, seen);
        chk("still_loading", busy, 1);
        chk("no_done_while_loading", done_cnt - d0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
